// File: rtl/dmem_dump_if.sv
// ============================================================================
// dmem_dump_if : start/bus/stream bundle between the dump reader, data memory
//                second read port and the host-side consumer.
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface dmem_dump_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              cpu_hold;
  logic              done;

  modport master (
    input  start, base_addr, word_count, mem_rdata, out_ready,
    output mem_addr, out_data, out_valid, busy, cpu_hold, done
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, out_ready,
    input  mem_addr, out_data, out_valid, busy, cpu_hold, done
  );
endinterface

`default_nettype wire

// File: rtl/dmem_dump_reader.sv
// ============================================================================
// dmem_dump_reader : streams a contiguous range of data-memory words out over
//                    valid/ready while holding the CPU frozen.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module dmem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  dmem_dump_if.master dump_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_d;

  // Address increment wraps naturally at 2**ADDR_W.
  assign addr_d = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (dump_if.start) begin
            busy_q <= 1'b1;
            if (dump_if.word_count != '0) begin
              addr_q      <= dump_if.base_addr;
              remaining_q <= dump_if.word_count;
              state_q     <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          out_data_q  <= dump_if.mem_rdata;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (dump_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (remaining_q == C_ONE) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              addr_q      <= addr_d;
              remaining_q <= remaining_q - C_ONE;
              state_q     <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // addr_q only moves on start or handshake, so mem_addr holds outside FETCH.
  assign dump_if.mem_addr  = addr_q;
  assign dump_if.out_data  = out_data_q;
  assign dump_if.out_valid = out_valid_q;
  assign dump_if.busy      = busy_q;
  assign dump_if.cpu_hold  = busy_q;
  assign dump_if.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_dump_reader.sv
`default_nettype none

module tb_dmem_dump_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_dump_if #(.ADDR_W(10), .DATA_W(32)) dif ();

  dmem_dump_reader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .dump_if (dif)
  );

  logic [31:0] mem [0:1023];
  assign dif.mem_rdata = mem[dif.mem_addr];

  typedef struct {
    logic [9:0]       base;
    logic [10:0]      count;
    int               stall_word;
    int               stall;
    bit               restart;
    int               n_exp;
    logic [3:0][31:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] got [$];
  int  done_cnt   = 0;
  bit  prev_stall = 1'b0;
  logic [31:0] held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Negedge monitor: a word counts when valid&&ready is seen before the edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, dif.out_valid}, 64'd1);
        chk("hold_data", {32'd0, dif.out_data}, {32'd0, held});
      end
      if (dif.out_valid && dif.out_ready) got.push_back(dif.out_data);
      if (dif.done) done_cnt++;
      if (dif.cpu_hold !== dif.busy) chk("hold_eq_busy", {63'd0, dif.cpu_hold}, {63'd0, dif.busy});
      prev_stall = dif.out_valid && !dif.out_ready;
      held       = dif.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (dif.busy && cyc < 300) begin
      tick();
      cyc++;
    end
    if (cyc >= 300) chk({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int stalled = 0;
    got.delete();
    done_cnt = 0;
    dif.start      = 1'b1;
    dif.base_addr  = v.base;
    dif.word_count = v.count;
    dif.out_ready  = 1'b1;
    tick();
    dif.start = 1'b0;
    while (done_cnt == 0 && cyc < 200) begin
      if (v.restart && (cyc == 1 || cyc == 4)) begin
        dif.start      = 1'b1;
        dif.base_addr  = 10'h100;
        dif.word_count = 11'd1;
      end else begin
        dif.start = 1'b0;
      end
      if (dif.out_valid && got.size() == v.stall_word && stalled < v.stall) begin
        dif.out_ready = 1'b0;
        stalled++;
      end else begin
        dif.out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    dif.start = 1'b0;
    if (cyc >= 200) chk($sformatf("v%0d_timeout", idx), 64'd1, 64'd0);
    tick();
    tick();
    chk($sformatf("v%0d_nwords", idx), got.size(), v.n_exp);
    for (int i = 0; i < v.n_exp && i < got.size(); i++)
      chk($sformatf("v%0d_word%0d", idx, i), {32'd0, got[i]}, {32'd0, v.exp[i]});
    chk($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
    chk($sformatf("v%0d_busy_end", idx), {63'd0, dif.busy}, 64'd0);
  endtask

  function automatic vec_t mk(input logic [9:0] b, input logic [10:0] c, input int sw, input int st,
                              input bit rs, input int n, input logic [3:0][31:0] e);
    vec_t v;
    v.base = b; v.count = c; v.stall_word = sw; v.stall = st;
    v.restart = rs; v.n_exp = n; v.exp = e;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + i;
    mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC;
    mem[10'h3FF] = 32'h11; mem[0] = 32'h22;

    vecs[0] = mk(10'd4,   11'd3, -1, 0, 1'b0, 3, {32'h0, 32'hC, 32'hB, 32'hA});
    vecs[1] = mk(10'd4,   11'd3,  1, 5, 1'b0, 3, {32'h0, 32'hC, 32'hB, 32'hA});
    vecs[2] = mk(10'd4,   11'd0, -1, 0, 1'b0, 0, {32'h0, 32'h0, 32'h0, 32'h0});
    vecs[3] = mk(10'h3FF, 11'd2, -1, 0, 1'b0, 2, {32'h0, 32'h0, 32'h22, 32'h11});
    vecs[4] = mk(10'd4,   11'd3, -1, 0, 1'b1, 3, {32'h0, 32'hC, 32'hB, 32'hA});
    vecs[5] = mk(10'd8,   11'd1,  0, 3, 1'b0, 1, {32'h0, 32'h0, 32'h0, 32'h5A00_0008});

    dif.start = 1'b0; dif.base_addr = '0; dif.word_count = '0; dif.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", {63'd0, dif.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, dif.busy}, 64'd0);
    chk("rst_hold", {63'd0, dif.cpu_hold}, 64'd0);
    chk("rst_done", {63'd0, dif.done}, 64'd0);
    chk("rst_data", {32'd0, dif.out_data}, 64'd0);
    chk("rst_addr", {54'd0, dif.mem_addr}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Latency: FETCH follows the start edge, word presented after the next one.
    dif.start = 1'b1; dif.base_addr = 10'd4; dif.word_count = 11'd1; dif.out_ready = 1'b0;
    tick();
    dif.start = 1'b0;
    chk("lat_busy", {63'd0, dif.busy}, 64'd1);
    chk("lat_valid0", {63'd0, dif.out_valid}, 64'd0);
    chk("lat_addr", {54'd0, dif.mem_addr}, 64'd4);
    tick();
    chk("lat_valid1", {63'd0, dif.out_valid}, 64'd1);
    chk("lat_data", {32'd0, dif.out_data}, 64'hA);
    dif.out_ready = 1'b1;
    tick();
    chk("lat_fin_valid", {63'd0, dif.out_valid}, 64'd0);
    chk("lat_fin_done", {63'd0, dif.done}, 64'd1);
    chk("lat_fin_busy", {63'd0, dif.busy}, 64'd1);
    tick();
    chk("lat_idle_busy", {63'd0, dif.busy}, 64'd0);
    chk("lat_idle_done", {63'd0, dif.done}, 64'd0);
    chk("lat_addr_hold", {54'd0, dif.mem_addr}, 64'd4);

    // Zero-count dump: one busy cycle carrying the done pulse.
    dif.start = 1'b1; dif.base_addr = 10'd9; dif.word_count = 11'd0;
    tick();
    dif.start = 1'b0;
    chk("z_busy", {63'd0, dif.busy}, 64'd1);
    chk("z_done", {63'd0, dif.done}, 64'd1);
    chk("z_valid", {63'd0, dif.out_valid}, 64'd0);
    tick();
    chk("z_busy_off", {63'd0, dif.busy}, 64'd0);
    chk("z_done_off", {63'd0, dif.done}, 64'd0);

    // Reset while word 2 of 4 is waiting in SEND.
    got.delete();
    dif.start = 1'b1; dif.base_addr = 10'd16; dif.word_count = 11'd4; dif.out_ready = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int c = 0; c < 20 && !(dif.out_valid && got.size() == 1); c++) tick();
    dif.out_ready = 1'b0;
    chk("mid_in_send", {63'd0, dif.out_valid}, 64'd1);
    chk("mid_word2", {32'd0, dif.out_data}, 64'h5A00_0011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {63'd0, dif.out_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, dif.busy}, 64'd0);
    chk("mid_rst_addr", {54'd0, dif.mem_addr}, 64'd0);
    run_vec(mk(10'd20, 11'd2, -1, 0, 1'b0, 2, {32'h0, 32'h0, 32'h5A00_0015, 32'h5A00_0014}), 6);
    wait_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
